// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and response signal bundle for alu_cmd_sequencer.
// slave is the sequencer side; master is the environment side.
interface alu_cmd_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [12:0]      cmd_x;
  logic [12:0]      cmd_y;
  logic [TAG_W-1:0] cmd_tag;

  logic [12:0]      alu_x;
  logic [12:0]      alu_y;
  logic [2:0]       alu_opcode;
  logic [12:0]      alu_result;
  logic             alu_status;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [12:0]      rsp_result;
  logic             rsp_status;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_tag,
    output cmd_ready,
    output alu_x, alu_y, alu_opcode,
    input  alu_result, alu_status,
    output rsp_valid, rsp_result, rsp_status, rsp_tag, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_tag,
    input  cmd_ready,
    input  alu_x, alu_y, alu_opcode,
    output alu_result, alu_status,
    input  rsp_valid, rsp_result, rsp_status, rsp_tag, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands in a FIFO and sequences them through an external ALU.
// Optional divide-by-zero screening: define ALU_DIVZERO_CHK_EN.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic             aclk,
  input logic             aresetn,
  alu_cmd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]       op;
    logic [12:0]      x;
    logic [12:0]      y;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  cmd_t             mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             full, empty;
  logic             push, pop;
  cmd_t             head;
  logic             dz;

  state_t           state, state_d;
  logic             load_alu, load_rsp, load_dz, rsp_clr;
  logic [TAG_W-1:0] tag_q;

  assign full          = (count == (AW+1)'(DEPTH));
  assign empty         = (count == '0);
  assign bus.cmd_ready = !full;
  assign push          = bus.cmd_valid && !full;
  assign head          = mem[rptr];

`ifdef ALU_DIVZERO_CHK_EN
  assign dz = ((head.op == 3'b011) || (head.op == 3'b100))
            && (head.y == '0);
`else
  assign dz = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (push) begin
      mem[wptr] <= '{op: bus.cmd_op, x: bus.cmd_x,
                     y: bus.cmd_y, tag: bus.cmd_tag};
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_d;
  end

  // A pop either issues to the ALU or, when screened, answers directly.
  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    load_alu = 1'b0;
    load_rsp = 1'b0;
    load_dz  = 1'b0;
    rsp_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (dz) begin
            load_dz = 1'b1;
            state_d = HOLD;
          end else begin
            load_alu = 1'b1;
            state_d  = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        load_rsp = 1'b1;
        state_d  = HOLD;
      end
      HOLD: begin
        if (bus.rsp_ready) begin
          rsp_clr = 1'b1;
          state_d = IDLE;
          if (!empty) begin
            pop = 1'b1;
            if (dz) begin
              load_dz = 1'b1;
              state_d = HOLD;
            end else begin
              load_alu = 1'b1;
              state_d  = ISSUE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bus.alu_x      <= '0;
      bus.alu_y      <= '0;
      bus.alu_opcode <= '0;
      tag_q          <= '0;
    end else if (load_alu) begin
      bus.alu_x      <= head.x;
      bus.alu_y      <= head.y;
      bus.alu_opcode <= head.op;
      tag_q          <= head.tag;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_status <= 1'b0;
      bus.rsp_tag    <= '0;
      bus.rsp_err    <= 1'b0;
    end else begin
      unique case (1'b1)
        load_rsp: begin
          bus.rsp_valid  <= 1'b1;
          bus.rsp_result <= bus.alu_result;
          bus.rsp_status <= bus.alu_status;
          bus.rsp_tag    <= tag_q;
          bus.rsp_err    <= 1'b0;
        end
        load_dz: begin
          bus.rsp_valid  <= 1'b1;
          bus.rsp_result <= '0;
          bus.rsp_status <= 1'b1;
          bus.rsp_tag    <= head.tag;
          bus.rsp_err    <= 1'b1;
        end
        rsp_clr: bus.rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a registered ALU model.
// Build with ALU_DIVZERO_CHK_EN to exercise divide-by-zero screening.
module tb_alu_cmd_sequencer;
  localparam int TAG_W = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  alu_cmd_sequencer_if #(.TAG_W(TAG_W)) ifc ();

  alu_cmd_sequencer #(
    .DEPTH (4),
    .TAG_W (TAG_W)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (ifc.slave)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [12:0]      res;
    logic             st;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [12:0] x;
    logic [12:0] y;
    logic [12:0] res;
    logic        st;
    logic        err;
  } vec_t;

  vec_t vt [14];
  rsp_t exp_q [$];
  int   checks = 0;
  int   fails  = 0;
  int   rdy_mode = 1;

  // Downstream ALU: result/status registered one clock after operands.
  function automatic logic [13:0] alu_fn(
    input logic [2:0] op, input logic [12:0] x, input logic [12:0] y);
    logic [12:0] r;
    logic        dz;
    dz = (op == 3'b011 || op == 3'b100) && (y == 13'd0);
    case (op)
      3'b000: r = x;
      3'b001: r = x + y;
      3'b010: r = x - y;
      3'b011: r = dz ? 13'h1FFF : x / y;
      3'b100: r = dz ? 13'h1FFF : x % y;
      3'b101: r = x & y;
      3'b110: r = x >> 1;
      default: r = x ^ y;
    endcase
    return {dz ? 1'b1 : (r == 13'd0), r};
  endfunction

  always @(posedge aclk)
    {ifc.alu_status, ifc.alu_result} <=
      alu_fn(ifc.alu_opcode, ifc.alu_x, ifc.alu_y);

  always begin
    @(posedge aclk);
    #2;
    if (rdy_mode == 2) ifc.rsp_ready = 1'($urandom_range(0, 1));
    else               ifc.rsp_ready = (rdy_mode == 1);
  end

  rsp_t prev_pl;
  logic prev_stall = 1'b0;

  always @(negedge aclk) begin
    rsp_t cur;
    rsp_t e;
    cur = '{res: ifc.rsp_result, st: ifc.rsp_status,
            tag: ifc.rsp_tag, err: ifc.rsp_err};
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!ifc.rsp_valid || cur !== prev_pl) begin
          fails++;
          $display("FAIL stall_hold: got v=%b %h want v=1 %h",
                   ifc.rsp_valid, cur, prev_pl);
        end
      end
      if (ifc.rsp_valid && ifc.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rsp: got %h want none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            fails++;
            $display("FAIL rsp: got res=%h st=%b tag=%h err=%b want res=%h st=%b tag=%h err=%b",
                     cur.res, cur.st, cur.tag, cur.err,
                     e.res, e.st, e.tag, e.err);
          end
        end
      end
      prev_stall = ifc.rsp_valid && !ifc.rsp_ready;
      prev_pl    = cur;
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_rsp"},
          {ifc.rsp_valid, ifc.rsp_result, ifc.rsp_status,
           ifc.rsp_tag, ifc.rsp_err}, 32'd0);
    check({nm, "_alu"},
          {ifc.alu_x, ifc.alu_y, ifc.alu_opcode}, 32'd0);
    check({nm, "_cmd_ready"}, 32'(ifc.cmd_ready), 32'd1);
  endtask

  task automatic send(input int v, input logic [TAG_W-1:0] tag);
    int n;
    ifc.cmd_op    = vt[v].op;
    ifc.cmd_x     = vt[v].x;
    ifc.cmd_y     = vt[v].y;
    ifc.cmd_tag   = tag;
    ifc.cmd_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge aclk);
      if (ifc.cmd_ready) break;
      n++;
      if (n > 300) begin
        checks++;
        fails++;
        $display("FAIL cmd_accept: got no cmd_ready want accept");
        ifc.cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge aclk);
    exp_q.push_back('{res: vt[v].res, st: vt[v].st,
                      tag: tag, err: vt[v].err});
    #1 ifc.cmd_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge aclk);
      n++;
    end
    check({nm, "_drain"}, exp_q.size(), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
  endtask

  initial begin
    int bad;
    vt[0]  = '{3'b001, 13'd5,      13'd7,      13'd12,     1'b0, 1'b0};
    vt[1]  = '{3'b010, 13'd9,      13'd9,      13'd0,      1'b1, 1'b0};
    vt[2]  = '{3'b110, 13'h1FFF,   13'd0,      13'h0FFF,   1'b0, 1'b0};
    vt[3]  = '{3'b000, 13'h1234,   13'h0ABC,   13'h1234,   1'b0, 1'b0};
    vt[4]  = '{3'b011, 13'd100,    13'd7,      13'd14,     1'b0, 1'b0};
    vt[5]  = '{3'b100, 13'd100,    13'd7,      13'd2,      1'b0, 1'b0};
    vt[6]  = '{3'b101, 13'h0F0F,   13'h00FF,   13'h000F,   1'b0, 1'b0};
    vt[7]  = '{3'b111, 13'h0AAA,   13'h0555,   13'h0FFF,   1'b0, 1'b0};
    vt[8]  = '{3'b001, 13'h1FFF,   13'd1,      13'd0,      1'b1, 1'b0};
    vt[9]  = '{3'b010, 13'd3,      13'd5,      13'h1FFE,   1'b0, 1'b0};
    vt[10] = '{3'b110, 13'd2,      13'd0,      13'd1,      1'b0, 1'b0};
    vt[11] = '{3'b111, 13'h1234,   13'h1234,   13'd0,      1'b1, 1'b0};
`ifdef ALU_DIVZERO_CHK_EN
    vt[12] = '{3'b011, 13'd100,    13'd0,      13'd0,      1'b1, 1'b1};
`else
    vt[12] = '{3'b011, 13'd100,    13'd0,      13'h1FFF,   1'b1, 1'b0};
`endif
    vt[13] = '{3'b101, 13'h1FFF,   13'd0,      13'd0,      1'b1, 1'b0};

    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = '0;
    ifc.cmd_x     = '0;
    ifc.cmd_y     = '0;
    ifc.cmd_tag   = '0;

    repeat (3) @(posedge aclk);
    #1 check_reset("por");
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    send(0, 4'd3);
    repeat (3) @(negedge aclk);
    check("latency_early", 32'(ifc.rsp_valid), 32'd0);
    @(negedge aclk);
    check("latency", 32'(ifc.rsp_valid), 32'd1);
    drain("single");

    for (int i = 1; i < 12; i++) send(i, 4'(i));
    drain("vectors");

    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1;
    for (int i = 0; i < 5; i++) send(i, 4'(i));
    @(negedge aclk);
    check("full_ready", 32'(ifc.cmd_ready), 32'd0);
    repeat (3) @(negedge aclk);
    check("full_hold", {31'(ifc.cmd_ready), ifc.rsp_valid}, 32'd1);
    rdy_mode = 1;
    drain("full");

    send(0, 4'd1);
    drain("pre_dz");
    send(12, 4'd7);
    drain("dz");
    @(negedge aclk);
`ifdef ALU_DIVZERO_CHK_EN
    check("dz_alu", {ifc.alu_x, ifc.alu_y, ifc.alu_opcode},
          {13'd5, 13'd7, 3'b001});
`else
    check("dz_alu", {ifc.alu_x, ifc.alu_y, ifc.alu_opcode},
          {13'd100, 13'd0, 3'b011});
`endif
    @(posedge aclk);
    #1;

    send(4, 4'd1);
    send(5, 4'd2);
    send(6, 4'd3);
    aresetn = 1'b0;
    exp_q.delete();
    #1 check_reset("mid");
    @(posedge aclk);
    #1 aresetn = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge aclk);
      if (ifc.rsp_valid) bad++;
    end
    check("post_reset_quiet", bad, 32'd0);
    check("post_reset_ready", 32'(ifc.cmd_ready), 32'd1);
    @(posedge aclk);
    #1;

    rdy_mode = 2;
    for (int i = 0; i < 50; i++) send(i % 14, 4'(i));
    drain("random");
    rdy_mode = 1;
    repeat (3) @(posedge aclk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter TAG_W, default 4, width of command/response tag.
REQ-003 aclk  in  1  sole clock; all state updates on rising edge.
REQ-004 aresetn  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  upstream command present.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_op  in  3  ALU opcode; cmd_x, cmd_y  in  13 each  operands; cmd_tag  in  TAG_W  command id.
REQ-008 alu_x, alu_y  out  13 each; alu_opcode  out  3  registered drive to the downstream ALU.
REQ-009 alu_result  in  13; alu_status  in  1  registered ALU outputs, valid one clock after operands are presented.
REQ-010 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-011 rsp_result  out  13; rsp_status  out  1; rsp_tag  out  TAG_W; rsp_err  out  1  response payload.

Function
REQ-012 Command accepted on a rising edge with cmd_valid && cmd_ready; pushed into a DEPTH-entry FIFO.
REQ-013 cmd_ready SHALL equal !full; no bypass when full, even if a pop occurs that cycle.
REQ-014 Simultaneous push and pop SHALL leave occupancy unchanged; read/write pointers wrap modulo DEPTH.
REQ-015 FSM states: IDLE, ISSUE, WAIT, HOLD.
REQ-016 IDLE: if FIFO non-empty, pop head, load alu_x/alu_y/alu_opcode and internal tag register, go ISSUE; else stay.
REQ-017 ISSUE: operands held stable one full cycle for ALU capture; unconditionally go WAIT.
REQ-018 WAIT: capture alu_result, alu_status, stored tag into rsp_* registers, rsp_err=0, set rsp_valid=1, go HOLD.
REQ-019 HOLD: rsp_* held stable while rsp_valid && !rsp_ready.
REQ-020 HOLD with rsp_ready=1: clear rsp_valid; if FIFO non-empty pop and go ISSUE same edge, else go IDLE.
REQ-021 Latency: command pushed into empty FIFO in IDLE at edge T gives rsp_valid=1 from edge T+3; back-to-back throughput one response per 3 cycles with rsp_ready held 1.
REQ-022 alu_x/alu_y/alu_opcode SHALL retain last issued values outside ISSUE.
REQ-023 Responses SHALL be delivered in acceptance order, one per command; none dropped or duplicated.

Reset
REQ-024 aresetn low SHALL immediately clear FIFO pointers and count, state=IDLE, rsp_valid=0, rsp_result=0, rsp_status=0, rsp_tag=0, rsp_err=0, alu_x=0, alu_y=0, alu_opcode=000.
REQ-025 cmd_ready SHALL be 1 once aresetn is high (FIFO empty).
REQ-026 Reset mid-operation discards buffered and in-flight commands; no response for them after release.

Configuration
REQ-027 Macro ALU_DIVZERO_CHK_EN SHALL gate divide-by-zero screening.
REQ-028 Defined: on pop of opcode 011 or 100 with y==0, do not update alu_* and go directly to HOLD with rsp_result=0, rsp_status=1, rsp_err=1, rsp_tag=command tag (rsp_valid 1 cycle after pop).
REQ-029 Not defined: such commands are issued normally; rsp_err SHALL be constant 0.

Verification
REQ-030 Single cmd op=001 x=5 y=7 tag=3 into idle block, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_result=12, rsp_status=0, rsp_tag=3.
REQ-031 Push 5 commands (tags 0..4) with rsp_ready=0, DEPTH=4 -> cmd_ready low after 4th buffered entry plus 1 in flight; release rsp_ready -> tags 0..4 in order, no loss.
REQ-032 op=010 x=9 y=9 -> rsp_result=0, rsp_status=1; op=110 x=13'h1FFF -> rsp_result=13'h0FFF.
REQ-033 aresetn pulsed low while in WAIT with 2 commands queued -> all outputs at reset values, cmd_ready=1, no response after release.
REQ-034 With ALU_DIVZERO_CHK_EN, op=011 x=100 y=0 tag=7 -> rsp_result=0, rsp_status=1, rsp_err=1, rsp_tag=7, alu_* unchanged; without macro, rsp_err=0.
REQ-035 rsp_ready toggled randomly over 50 mixed commands -> rsp_* stable while stalled, results match reference model in order.
